// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receiver.
// Optional even-parity bit is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int FIFO_AW_DEF = 2;
  localparam int OVERSAMPLE  = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif
endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO; an occupancy counter one bit wider than the pointers
// tells full from empty. Storage is cleared on reset so dout reads 0.
module uart_rx_fifo #(
  parameter int DBIT    = 8,
  parameter int FIFO_AW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [DBIT-1:0] din,
  output logic [DBIT-1:0] dout,
  output logic            empty,
  output logic            full
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);

  logic [DBIT-1:0]    mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  // A pop in the same cycle frees the slot the push is about to use.
  assign do_push = push && ((count != CNT_FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
endmodule

// File: rtl/uart_rx_unit.sv
// 16x-oversampling UART receiver feeding a small FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic [9:0]      divsr,
  input  logic            rd_uart,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty,
  output logic            rx_full,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun
);
  localparam int              NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [3:0]      MID       = 4'(OVERSAMPLE/2 - 1);
  localparam logic [3:0]      LAST      = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      STOP_LAST = 4'(SB_TICK - 1);
  localparam logic [NW-1:0]   NLAST     = NW'(DBIT - 1);

  logic            rx_meta, rx_sync;
  logic [9:0]      cnt, div_q;
  logic            tick;
  rx_state_t       state;
  logic [3:0]      s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] shreg;
  logic            bad;
  logic            stop_tick, push, pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Divisor is latched only at wrap so a mid-period change never truncates a tick.
  assign tick = (cnt == div_q);
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      div_q <= divsr;
    end else if (tick) begin
      cnt   <= '0;
      div_q <= divsr;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign pop       = rd_uart && !rx_empty;
  assign stop_tick = (state == STOP) && tick && (s == STOP_LAST);
  assign push      = stop_tick && rx_sync && !bad && (!rx_full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      s          <= '0;
      n          <= '0;
      shreg      <= '0;
      bad        <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      case (state)
        IDLE: if (!rx_sync) begin
          state <= START;
          s     <= '0;
        end
        START: if (tick) begin
          if (s == MID) begin
            s     <= '0;
            n     <= '0;
            bad   <= 1'b0;
            state <= rx_sync ? IDLE : DATA;
          end else s <= s + 1'b1;
        end
        DATA: if (tick) begin
          if (s == LAST) begin
            s     <= '0;
            shreg <= {rx_sync, shreg[DBIT-1:1]};
            if (n == NLAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else n <= n + 1'b1;
          end else s <= s + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          if (s == LAST) begin
            s     <= '0;
            state <= STOP;
            if (rx_sync != ^shreg) begin
              parity_err <= 1'b1;
              bad        <= 1'b1;
            end
          end else s <= s + 1'b1;
        end
`endif
        STOP: if (tick) begin
          if (s == STOP_LAST) begin
            s     <= '0;
            state <= IDLE;
            if (!rx_sync)                   frame_err <= 1'b1;
            else if (!bad && rx_full && !pop) overrun <= 1'b1;
          end else s <= s + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(.DBIT(DBIT), .FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (shreg),
    .dout  (r_data),
    .empty (rx_empty),
    .full  (rx_full)
  );
endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed + randomized bench for uart_rx_unit against a queue-based model.
module tb_uart_rx_unit;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, rd_uart = 1'b0;
  logic [9:0] divsr = 10'd3;
  logic [7:0] r_data;
  logic       rx_empty, rx_full, frame_err, parity_err, overrun;

  int n_chk = 0, n_fail = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
  int snap_fe, snap_pe, snap_ov, lat;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  uart_rx_unit dut (
    .clk(clk), .reset(reset), .rx(rx), .divsr(divsr), .rd_uart(rd_uart),
    .r_data(r_data), .rx_empty(rx_empty), .rx_full(rx_full),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  // Count high cycles of each pulse; a single one-cycle pulse adds exactly 1.
  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
    if (overrun)    ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_fifo(input string tag);
    check({tag, "/empty"}, 32'(rx_empty), 32'(q.size() == 0));
    check({tag, "/full"},  32'(rx_full),  32'(q.size() == DEPTH));
    if (q.size() != 0) check({tag, "/head"}, 32'(r_data), 32'(q[0]));
  endtask

  task automatic snap();
    snap_fe = fe_cnt;
    snap_pe = pe_cnt;
    snap_ov = ov_cnt;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "/fe"}, 32'(fe_cnt - snap_fe), 0);
    check({tag, "/pe"}, 32'(pe_cnt - snap_pe), 0);
    check({tag, "/ov"}, 32'(ov_cnt - snap_ov), 0);
  endtask

  // Drive one frame (called at a negedge); optionally pop pop_at-1 negedges in.
  task automatic frame(input string tag, input logic [7:0] d, input logic stop_ok,
                       input logic par_bad, input int pop_at);
    int         bp = 16 * (int'(divsr) + 1);
    int         fe0 = fe_cnt, pe0 = pe_cnt, ov0 = ov_cnt;
    bit         bad_par = PAR_EN && par_bad;
    bit         ov = 1'b0;
    logic [7:0] popped = '0;
    fork
      begin
        rx = 1'b0; repeat (bp) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rx = d[i]; repeat (bp) @(negedge clk);
        end
        if (PAR_EN) begin
          rx = (^d) ^ par_bad; repeat (bp) @(negedge clk);
        end
        if (stop_ok) begin
          rx = 1'b1; repeat (bp) @(negedge clk);
        end else begin
          rx = 1'b0; repeat (bp * 3 / 4) @(negedge clk);
          rx = 1'b1; repeat (bp - bp * 3 / 4) @(negedge clk);
        end
      end
      begin
        if (pop_at > 0) begin
          repeat (pop_at - 1) @(negedge clk);
          popped  = r_data;
          rd_uart = 1'b1;
          @(negedge clk);
          rd_uart = 1'b0;
        end
      end
    join
    repeat (4) @(negedge clk);
    if (pop_at > 0 && q.size() != 0) begin
      check({tag, "/pop_head"}, 32'(popped), 32'(q[0]));
      void'(q.pop_front());
    end
    if (stop_ok && !bad_par) begin
      if (q.size() == DEPTH) ov = 1'b1;
      else q.push_back(d);
    end
    check({tag, "/frame_err"},  32'(fe_cnt - fe0), 32'(!stop_ok));
    check({tag, "/parity_err"}, 32'(pe_cnt - pe0), 32'(bad_par));
    check({tag, "/overrun"},    32'(ov_cnt - ov0), 32'(ov));
    check_fifo(tag);
  endtask

  task automatic pop_chk(input string tag);
    if (q.size() != 0) begin
      check({tag, "/pop_head"}, 32'(r_data), 32'(q[0]));
      void'(q.pop_front());
    end
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
    @(negedge clk);
    check_fifo(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst/r_data", 32'(r_data), 0);
    check("rst/empty", 32'(rx_empty), 1);
    check("rst/full", 32'(rx_full), 0);
    check("rst/pulses", 32'({frame_err, parity_err, overrun}), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    frame("a5", 8'hA5, 1'b1, 1'b0, 0);
    pop_chk("a5_rd");

    // 8-clock low glitch = 2 ticks at divsr=3
    snap();
    rx = 1'b0; repeat (8) @(negedge clk);
    rx = 1'b1; repeat (192) @(negedge clk);
    check_quiet("glitch");
    check_fifo("glitch");

    frame("fe3c", 8'h3C, 1'b0, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      divsr = 10'($urandom_range(0, 3));
      repeat (8) @(negedge clk);
      frame("rnd", 8'($urandom), 1'b1, 1'b0, 0);
      if ($urandom_range(0, 1) == 1) pop_chk("rnd_rd");
    end
    while (q.size() != 0) pop_chk("drain");
    pop_chk("empty_pop");

    divsr = 10'd3;
    repeat (8) @(negedge clk);
    for (int i = 1; i <= 5; i++) frame("fill", 8'(i), 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) pop_chk("fill_rd");

    // Find the push cycle on an empty FIFO at divsr=0 (fixed latency), then
    // pop exactly on that cycle with the FIFO full.
    divsr = 10'd0;
    repeat (8) @(negedge clk);
    fork
      frame("cal", 8'h77, 1'b1, 1'b0, 0);
      begin
        lat = 0;
        while (rx_empty && lat < 4000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("cal/seen", 32'(lat < 4000), 1);
    pop_chk("cal_rd");
    for (int i = 0; i < 4; i++) frame("pp_fill", 8'(8'h10 + i), 1'b1, 1'b0, 0);
    frame("pp", 8'h99, 1'b1, 1'b0, lat);
    for (int i = 0; i < 4; i++) pop_chk("pp_rd");

    // Reset during DATA, then a clean frame
    divsr = 10'd3;
    repeat (8) @(negedge clk);
    frame("pre", 8'hC3, 1'b1, 1'b0, 0);
    snap();
    rx = 1'b0; repeat (64) @(negedge clk);
    rx = 1'b1; repeat (64) @(negedge clk);
    rx = 1'b0; repeat (32) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rx    = 1'b1;
    q.delete();
    repeat (700) @(negedge clk);
    check_quiet("rst_mid");
    check_fifo("rst_mid");
    frame("rst_5a", 8'h5A, 1'b1, 1'b0, 0);
    pop_chk("rst_5a_rd");
    frame("par", 8'h5A, 1'b1, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
